// File: rtl/matmul_tile_seq.sv
// rtl/matmul_tile_seq.sv - 4x4 uint8 matrix product tiled onto a shared 2x2 matmul datapath
// Contains the 2x2 datapath (matmul) and the tiling sequencer (matmul_tile_seq).

module matmul #(
  parameter int OutputReg = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] c_o
);

  logic [63:0] res_d;
  logic [63:0] res_q;

  function automatic logic [15:0] el2(input logic [31:0] m, input int r, input int c);
    return {8'd0, m[8*(3-(2*r+c)) +: 8]};
  endfunction

  always_comb begin
    res_d = '0;
    for (int n = 0; n < 4; n++) begin
      res_d[16*(3-n) +: 16] = el2(a_i, n/2, 0) * el2(b_i, 0, n%2)
                            + el2(a_i, n/2, 1) * el2(b_i, 1, n%2);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) res_q <= '0;
    else         res_q <= res_d;
  end

  assign c_o = (OutputReg != 0) ? res_q : res_d;

endmodule

module matmul_tile_seq #(
  parameter int OutputReg = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [127:0] a_i,
  input  logic [127:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [255:0] c_o
);

  localparam bit HasLat = (OutputReg != 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic   [2:0]   step_q;
  logic   [127:0] a_q, b_q;
  logic   [255:0] c_q, c_d;
  logic   [2:0]   tag_q;
  logic           tag_v_q;
  logic           accept;
  logic   [31:0]  op_a, op_b;
  logic   [63:0]  res;
  logic   [2:0]   wb_tag;
  logic           wb_v;

  function automatic logic [7:0] el4(input logic [127:0] m, input int r, input int c);
    return m[8*(15-(4*r+c)) +: 8];
  endfunction

  function automatic int idx16(input int r, input int c);
    return 16*(15-(4*r+c));
  endfunction

  assign accept = start_i && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (step_q == 3'd7) state_d = HasLat ? S_DRAIN : S_DONE;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = accept ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      tag_q   <= '0;
      tag_v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        step_q <= '0;
        a_q    <= a_i;
        b_q    <= b_i;
      end else if (state_q == S_RUN) begin
        step_q <= step_q + 3'd1;
      end
      c_q     <= c_d;
      tag_q   <= step_q;
      tag_v_q <= (state_q == S_RUN);
    end
  end

  // Step s issues tile (i,j)=(s[2],s[1]) with k=s[0]: A block (i,k) times B block (k,j).
  always_comb begin
    op_a = {el4(a_q, 2*int'(step_q[2]),   2*int'(step_q[0])),
            el4(a_q, 2*int'(step_q[2]),   2*int'(step_q[0])+1),
            el4(a_q, 2*int'(step_q[2])+1, 2*int'(step_q[0])),
            el4(a_q, 2*int'(step_q[2])+1, 2*int'(step_q[0])+1)};
    op_b = {el4(b_q, 2*int'(step_q[0]),   2*int'(step_q[1])),
            el4(b_q, 2*int'(step_q[0]),   2*int'(step_q[1])+1),
            el4(b_q, 2*int'(step_q[0])+1, 2*int'(step_q[1])),
            el4(b_q, 2*int'(step_q[0])+1, 2*int'(step_q[1])+1)};
  end

  matmul #(.OutputReg(OutputReg)) u_matmul (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .a_i    (op_a),
    .b_i    (op_b),
    .c_o    (res)
  );

  // Write-back follows the tag of the returning result, not the current issue.
  assign wb_tag = HasLat ? tag_q : step_q;
  assign wb_v   = HasLat ? tag_v_q : (state_q == S_RUN);

  always_comb begin
    c_d = c_q;
    if (wb_v) begin
      for (int n = 0; n < 4; n++) begin
        if (wb_tag[0])
          c_d[idx16(2*int'(wb_tag[2]) + n/2, 2*int'(wb_tag[1]) + n%2) +: 16] =
            c_q[idx16(2*int'(wb_tag[2]) + n/2, 2*int'(wb_tag[1]) + n%2) +: 16]
            + res[16*(3-n) +: 16];
        else
          c_d[idx16(2*int'(wb_tag[2]) + n/2, 2*int'(wb_tag[1]) + n%2) +: 16] =
            res[16*(3-n) +: 16];
      end
    end
  end

  assign busy_o = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o = (state_q == S_DONE);
  assign c_o    = c_q;

endmodule

// File: tb/tb_matmul_tile_seq.sv
// tb/tb_matmul_tile_seq.sv - self-checking bench for matmul_tile_seq, both OutputReg settings

module tb_matmul_tile_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start_s [2];
  logic [127:0] a_s     [2];
  logic [127:0] b_s     [2];
  logic         busy_s  [2];
  logic         done_s  [2];
  logic [255:0] c_s     [2];

  matmul_tile_seq #(.OutputReg(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_s[0]), .a_i(a_s[0]), .b_i(b_s[0]),
    .busy_o(busy_s[0]), .done_o(done_s[0]), .c_o(c_s[0])
  );

  matmul_tile_seq #(.OutputReg(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_s[1]), .a_i(a_s[1]), .b_i(b_s[1]),
    .busy_o(busy_s[1]), .done_o(done_s[1]), .c_o(c_s[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic [255:0] c;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [255:0] ref_mm(input logic [127:0] a, input logic [127:0] b);
    int am [4][4];
    int bm [4][4];
    logic [255:0] c;
    c = '0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        am[r][k] = int'(a[8*(15-(4*r+k)) +: 8]);
        bm[r][k] = int'(b[8*(15-(4*r+k)) +: 8]);
      end
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        int s;
        s = 0;
        for (int n = 0; n < 4; n++) s += am[r][n] * bm[n][k];
        c[16*(15-(4*r+k)) +: 16] = s[15:0];
      end
    return c;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_job(input int u, input logic [127:0] a, input logic [127:0] b);
    a_s[u]     = a;
    b_s[u]     = b;
    start_s[u] = 1'b1;
    @(negedge clk);
    start_s[u] = 1'b0;
  endtask

  // Counts cycles since the start edge until done_o, bounded.
  task automatic wait_done(input int u, input int from, output int cyc);
    cyc = from;
    while (!done_s[u] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] ident, ramp, ta, tb2;
  logic [255:0] e;
  int           lat;
  int           ndone;

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start_s[u] = 1'b0;
      a_s[u]     = '0;
      b_s[u]     = '0;
    end

    ident = '0;
    ramp  = '0;
    for (int r = 0; r < 4; r++) ident[8*(15-5*r) +: 8] = 8'h01;
    for (int n = 0; n < 16; n++) ramp[8*(15-n) +: 8] = 8'(n);

    vecs[0].a = ident;
    vecs[0].b = ramp;
    for (int n = 0; n < 16; n++) vecs[0].c[16*(15-n) +: 16] = 16'(n);
    vecs[1].a = {16{8'hFF}};
    vecs[1].b = {16{8'hFF}};
    vecs[1].c = {16{16'hF804}};
    vecs[2].a = '0;
    vecs[2].b = rand128();
    vecs[2].c = '0;
    vecs[3].a = {16{8'h01}};
    vecs[3].b = {16{8'h02}};
    vecs[3].c = {16{16'h0008}};
    vecs[4].a = ramp;
    vecs[4].b = ident;
    for (int n = 0; n < 16; n++) vecs[4].c[16*(15-n) +: 16] = 16'(n);

    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("reset_busy", 256'(busy_s[u]), 256'(0));
      check("reset_done", 256'(done_s[u]), 256'(0));
      check("reset_c", c_s[u], '0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int u = 0; u < 2; u++) begin
      // Table vectors, issued back-to-back from each DONE cycle.
      for (int v = 0; v < 5; v++) begin
        start_job(u, vecs[v].a, vecs[v].b);
        wait_done(u, 1, lat);
        check("table_latency", 256'(lat), 256'(9 + u));
        check("table_c", c_s[u], vecs[v].c);
      end
      repeat (3) @(negedge clk);

      // Back-to-back with new operands started in the DONE cycle.
      ta  = rand128();
      tb2 = rand128();
      start_job(u, ramp, ramp);
      wait_done(u, 1, lat);
      check("b2b_first_c_in_done", c_s[u], ref_mm(ramp, ramp));
      start_job(u, ta, tb2);
      check("b2b_busy_after_restart", 256'(busy_s[u]), 256'(1));
      wait_done(u, 1, lat);
      check("b2b_second_latency", 256'(lat), 256'(9 + u));
      check("b2b_second_c", c_s[u], ref_mm(ta, tb2));
      repeat (3) @(negedge clk);

      // Start while busy is ignored; result uses originally captured operands.
      ta  = rand128();
      tb2 = rand128();
      start_job(u, ta, tb2);
      @(negedge clk);
      @(negedge clk);
      a_s[u]     = rand128();
      b_s[u]     = rand128();
      start_s[u] = 1'b1;
      @(negedge clk);
      start_s[u] = 1'b0;
      wait_done(u, 4, lat);
      check("busy_reject_latency", 256'(lat), 256'(9 + u));
      check("busy_reject_c", c_s[u], ref_mm(ta, tb2));
      ndone = 0;
      repeat (15) begin
        @(negedge clk);
        if (done_s[u]) ndone++;
      end
      check("busy_reject_single_done", 256'(ndone), 256'(0));

      // Reset mid-run aborts immediately.
      start_job(u, {16{8'hFF}}, rand128());
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_busy", 256'(busy_s[u]), 256'(0));
      check("midreset_done", 256'(done_s[u]), 256'(0));
      check("midreset_c", c_s[u], '0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (15) begin
        @(negedge clk);
        if (done_s[u]) ndone++;
      end
      check("midreset_no_done", 256'(ndone), 256'(0));

      // Random operands against the reference model.
      for (int t = 0; t < 1000; t++) begin
        ta  = rand128();
        tb2 = rand128();
        start_job(u, ta, tb2);
        wait_done(u, 1, lat);
        if (lat != 9 + u) check("rand_latency", 256'(lat), 256'(9 + u));
        e = ref_mm(ta, tb2);
        check("rand_c", c_s[u], e);
      end
      repeat (3) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
